// File: rtl/vx_ibuf_scoreboard.sv
// Single-entry issue stage: holds one instruction, blocks it on RAW/WAW hazards against a busy bitmap.
// Latency 1 cycle accept-to-issue; in_ready falls only when the held entry cannot issue this cycle.
module vx_ibuf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 16,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [RW-1:0]     in_rs3,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_wb,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [RW-1:0]     out_rd,
  output logic              out_wb,
  input  logic              out_ready,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic                entry_valid;
  logic [DATA_W-1:0]   e_data;
  logic [RW-1:0]       e_rs1, e_rs2, e_rs3, e_rd;
  logic                e_wb;
  logic [NUM_REGS-1:0] busy, busy_eff, busy_nxt;
  logic                hazard, issue, accept;

  // Writeback releases its register in the same cycle so a waiting consumer can issue immediately.
  always_comb begin
    busy_eff = busy;
    if (wb_valid) busy_eff[wb_rd] = 1'b0;
  end

  assign hazard    = entry_valid & (busy_eff[e_rs1] | busy_eff[e_rs2] | busy_eff[e_rs3] |
                                    (e_wb & busy_eff[e_rd]));
  assign out_valid = reset & entry_valid & ~hazard;
  assign issue     = out_valid & out_ready;
  assign in_ready  = reset & (~entry_valid | issue);
  assign accept    = in_valid & in_ready;

  assign out_data  = e_data;
  assign out_rd    = e_rd;
  assign out_wb    = e_wb;

  // Set is applied after the clear so a same-register issue/writeback leaves the bit busy.
  always_comb begin
    busy_nxt = busy_eff;
    if (issue && e_wb && (e_rd != '0)) busy_nxt[e_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_valid  <= 1'b0;
      busy         <= '0;
      stall_cycles <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept)     entry_valid <= 1'b1;
      else if (issue) entry_valid <= 1'b0;
      if (hazard && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      e_data <= in_data;
      e_rs1  <= in_rs1;
      e_rs2  <= in_rs2;
      e_rs3  <= in_rs3;
      e_rd   <= in_rd;
      e_wb   <= in_wb;
    end
  end

endmodule

// File: tb/tb_vx_ibuf_scoreboard.sv
// Directed scenarios; a negedge monitor checks every issued instruction against an expected queue.
module tb_vx_ibuf_scoreboard;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_wb, in_ready, out_valid, out_wb, out_ready, wb_valid;
  logic [63:0] in_data, out_data;
  logic [4:0]  in_rs1, in_rs2, in_rs3, in_rd, out_rd, wb_rd;
  logic [3:0]  stall_cycles;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        wb;
  } exp_t;

  exp_t exp_q[$];
  int   iss_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  vx_ibuf_scoreboard #(.NUM_REGS(32), .DATA_W(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs3(in_rs3), .in_rd(in_rd), .in_wb(in_wb), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_wb(out_wb),
    .out_ready(out_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake on the issue port must match the oldest expected instruction.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      iss_q.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got data %0h rd %0d, expected nothing", out_data, out_rd);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_rd, out_wb} !== e) begin
          n_err++;
          $display("FAIL issue_payload: got %0h/%0d/%0b expected %0h/%0d/%0b",
                   out_data, out_rd, out_wb, e.d, e.rd, e.wb);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] r3, input logic [4:0] rd, input logic wb, output int waits);
    exp_t e;
    in_valid = 1'b1; in_data = d; in_rs1 = r1; in_rs2 = r2; in_rs3 = r3; in_rd = rd; in_wb = wb;
    e.d = d; e.rd = rd; e.wb = wb;
    exp_q.push_back(e);
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        tick;
        break;
      end
      tick;
      waits++;
      if (waits > 50) begin
        n_err++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required high", waits);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] r);
    wb_valid = 1'b1; wb_rd = r;
    tick;
    wb_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_rd = '0; in_wb = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;

    // Reset state
    repeat (3) tick;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_cycles, 0);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    tick;

    // Back-to-back independent instructions
    iss_q.delete();
    for (int i = 1; i <= 4; i++) begin
      send(64'hB2B0_0000_0000_0000 + 64'(i), 0, 0, 0, 5'(i), 1'b1, w);
      chk("b2b_no_wait", w, 0);
    end
    tick; tick;
    chk("b2b_issue_count", iss_q.size(), 4);
    for (int i = 0; i + 1 < iss_q.size(); i++) chk("b2b_consecutive", iss_q[i+1] - iss_q[i], 1);
    for (int i = 1; i <= 4; i++) wb_pulse(5'(i));

    // RAW on r5 with same-cycle writeback bypass
    send(64'hAAAA_0005, 0, 0, 0, 5, 1'b1, w);
    tick; tick;
    send(64'hBBBB_0006, 5, 0, 0, 6, 1'b1, w);
    @(negedge clk);
    chk("raw_held", out_valid, 0);
    chk("raw_stall_start", stall_cycles, 0);
    tick; tick; tick;
    @(negedge clk);
    chk("raw_still_held", out_valid, 0);
    chk("raw_stall_3", stall_cycles, 3);
    tick;
    wb_valid = 1'b1; wb_rd = 5;
    @(negedge clk);
    chk("raw_bypass_issue", out_valid, 1);
    tick;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("raw_stall_final", stall_cycles, 4);
    tick;
    wb_pulse(6);

    // WAW on r7, then a non-writing rd=7 issues immediately
    send(64'hCCCC_0007, 0, 0, 0, 7, 1'b1, w);
    tick; tick;
    send(64'hDDDD_0007, 0, 0, 0, 7, 1'b1, w);
    @(negedge clk);
    chk("waw_held", out_valid, 0);
    tick;
    wb_valid = 1'b1; wb_rd = 7;
    @(negedge clk);
    chk("waw_release", out_valid, 1);
    tick;
    wb_valid = 1'b0;
    send(64'hEEEE_0007, 0, 0, 0, 7, 1'b0, w);
    @(negedge clk);
    chk("waw_nowb_issue", out_valid, 1);
    chk("waw_stall", stall_cycles, 5);
    tick;
    wb_pulse(7);

    // Same-register set and clear: set wins
    send(64'hF0F0_0003, 0, 0, 0, 3, 1'b1, w);
    tick; tick;
    send(64'hF1F1_0003, 0, 0, 0, 3, 1'b1, w);
    wb_valid = 1'b1; wb_rd = 3;
    @(negedge clk);
    chk("setclr_issue", out_valid, 1);
    tick;
    wb_valid = 1'b0;
    send(64'hF2F2_0000, 0, 3, 0, 0, 1'b0, w);
    @(negedge clk);
    chk("setclr_busy3_kept", out_valid, 0);
    tick;
    wb_valid = 1'b1; wb_rd = 3;
    @(negedge clk);
    chk("setclr_release", out_valid, 1);
    tick;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("setclr_stall", stall_cycles, 6);
    tick;

    // Register 0 is never marked busy
    send(64'h0000_0010, 0, 0, 0, 0, 1'b1, w);
    tick; tick;
    send(64'h0000_0011, 0, 0, 0, 0, 1'b1, w);
    @(negedge clk);
    chk("r0_never_busy", out_valid, 1);
    tick;

    // Backpressure
    out_ready = 1'b0;
    send(64'h5555_AAAA_5555_AAAA, 0, 0, 0, 8, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 64'h5555_AAAA_5555_AAAA);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall", stall_cycles, 6);
      tick;
    end
    out_ready = 1'b1;
    tick;

    // Stall counter saturation
    send(64'h9999_0009, 0, 0, 0, 9, 1'b1, w);
    tick; tick;
    send(64'h9999_000A, 0, 0, 9, 10, 1'b0, w);
    tick;
    repeat (8) tick;
    @(negedge clk);
    chk("stall_sat", stall_cycles, 15);
    tick; tick; tick;
    @(negedge clk);
    chk("stall_nowrap", stall_cycles, 15);
    tick;
    wb_valid = 1'b1; wb_rd = 9;
    @(negedge clk);
    chk("sat_release", out_valid, 1);
    tick;
    wb_valid = 1'b0;

    // Mid-operation reset with busy = 0xF0 and a held entry
    for (int i = 4; i <= 7; i++) send(64'h7000 + 64'(i), 0, 0, 0, 5'(i), 1'b1, w);
    tick; tick;
    send(64'hDEAD_BEEF, 4, 0, 0, 0, 1'b0, w);
    @(negedge clk);
    chk("pre_rst_held", out_valid, 0);
    tick;
    reset = 1'b0;
    chk("pre_rst_pending", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_stall", stall_cycles, 0);
    chk("after_rst_in_ready", in_ready, 1);
    tick;
    send(64'h1234_5678, 4, 5, 6, 7, 1'b1, w);
    @(negedge clk);
    chk("after_rst_busy_clear", out_valid, 1);
    tick; tick;

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
